micro_divider: RTL and testbench

- Sequential restoring shift-subtract divider: unsigned DVD_W-bit dividend / DVS_W-bit divisor -> DVD_W-bit quotient + DVS_W-bit remainder.
- Inverse companion to the team's 4x4 shift-add micro multiplier; sits beside it under the tt_um top, fed from ui_in/uio_in, results muxed onto uo_out.
- One quotient bit per clock; start/busy/done handshake.

---
 rtl/micro_divider_pkg.sv | 25 ++
 rtl/micro_div_step.sv | 27 ++
 rtl/micro_divider.sv | 99 +++++++++
 tb/tb_micro_divider.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/micro_divider_pkg.sv
// rtl/micro_divider_pkg.sv - shared state enum, default widths and counter-width helper for the micro divider
package micro_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int MICRO_DVD_W = 8;
    localparam int MICRO_DVS_W = 4;

    function automatic int clog2(input int value);
        int v;
        int n;
        v = value - 1;
        n = 0;
        while (v > 0) begin
            n++;
            v = v >>> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/micro_div_step.sv
// rtl/micro_div_step.sv - one combinational restoring shift-compare-subtract step
module micro_div_step #(
    parameter int DVS_W = 4
) (
    input  logic [DVS_W:0]   r,
    input  logic [DVS_W-1:0] d,
    input  logic             in_bit,
    output logic [DVS_W:0]   r_next,
    output logic             q_bit
);

    logic [DVS_W:0] r_shift;
    logic [DVS_W:0] d_ext;

    assign r_shift = {r[DVS_W-1:0], in_bit};
    assign d_ext   = {1'b0, d};

    always_comb begin
        q_bit  = 1'b0;
        r_next = r_shift;
        if (r_shift >= d_ext) begin
            q_bit  = 1'b1;
            r_next = r_shift - d_ext;
        end
    end

endmodule

// File: rtl/micro_divider.sv
// rtl/micro_divider.sv - sequential restoring divider, one quotient bit per clock (optional MICRO_DIV_ZERO_TRAP_EN)
module micro_divider
    import micro_pkg::*;
#(
    parameter int DVD_W = MICRO_DVD_W,
    parameter int DVS_W = MICRO_DVS_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = (clog2(DVD_W) > 0) ? clog2(DVD_W) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [DVD_W-1:0] q;
    logic [DVS_W-1:0] d;
    logic [DVS_W:0]   r;
    logic [DVS_W:0]   r_next;
    logic             q_bit;
    logic [DVD_W-1:0] q_next;

    micro_div_step #(.DVS_W(DVS_W)) u_step (
        .r      (r),
        .d      (d),
        .in_bit (q[DVD_W-1]),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    // Dividend bits leave at the top of Q while quotient bits enter at the bottom.
    assign q_next = {q[DVD_W-2:0], q_bit};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= '0;
            d         <= '0;
            r         <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        q        <= dividend;
                        d        <= divisor;
                        r        <= '0;
                        cnt      <= CNT_W'(DVD_W - 1);
                        done     <= 1'b0;
                        div_zero <= 1'b0;
`ifdef MICRO_DIV_ZERO_TRAP_EN
                        if (divisor == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            div_zero  <= 1'b1;
                            quotient  <= '0;
                            remainder <= '0;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
`else
                        state <= RUN;
                        busy  <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    q   <= q_next;
                    r   <= r_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next[DVS_W-1:0];
                        div_zero  <= (d == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_micro_divider.sv
// tb/tb_micro_divider.sv - scoreboard bench for micro_divider (expectations follow MICRO_DIV_ZERO_TRAP_EN)
module tb_micro_divider;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    logic       sys_clk;
    logic       sys_rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_zero;

    exp_t sb[$];
    int   n_chk;
    int   n_bad;
    logic done_q;

    micro_divider #(.DVD_W(8), .DVS_W(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int q, input int r, input bit dz);
        exp_t e;
        e.q  = 8'(q);
        e.r  = 4'(r);
        e.dz = dz;
        return e;
    endfunction

    function automatic exp_t ref_model(input logic [7:0] a, input logic [3:0] b);
        if (b == 4'd0) begin
`ifdef MICRO_DIV_ZERO_TRAP_EN
            return mk(0, 0, 1'b1);
`else
            return mk(255, int'(a[3:0]), 1'b1);
`endif
        end
        return mk(int'(a) / int'(b), int'(a) % int'(b), 1'b0);
    endfunction

    // Monitor: each rising done pops one expected result.
    initial done_q = 1'b0;
    always @(negedge sys_clk) begin
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", int'(quotient), int'(e.q));
                chk("remainder", int'(remainder), int'(e.r));
                chk("div_zero", int'(div_zero), int'(e.dz));
            end
        end
        done_q = done;
    end

    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input exp_t e,
                          input int exp_lat, input bit inj);
        int n;
        int nb;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(e);
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        nb = busy ? 1 : 0;
        n  = 0;
        while (!done && n < 30) begin
            if (inj && n == 3) begin
                dividend = 8'd50;
                divisor  = 4'd5;
                start    = 1'b1;
            end
            @(posedge sys_clk);
            #1;
            start = 1'b0;
            n++;
            if (busy) nb++;
        end
        chk("latency", n, exp_lat);
        chk("busy_cycles", nb, exp_lat);
    endtask

    int lat_a;
    int lat_b;

    initial begin
        n_chk    = 0;
        n_bad    = 0;
        sys_rst  = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_div_zero", int'(div_zero), 0);

        run_op(8'd200, 4'd7, mk(28, 4, 1'b0), 8, 1'b0);
        run_op(8'd255, 4'd15, mk(17, 0, 1'b0), 8, 1'b0);
        run_op(8'd5, 4'd9, mk(0, 5, 1'b0), 8, 1'b0);
        run_op(8'd255, 4'd1, mk(255, 0, 1'b0), 8, 1'b0);
`ifdef MICRO_DIV_ZERO_TRAP_EN
        run_op(8'hA6, 4'd0, mk(0, 0, 1'b1), 0, 1'b0);
`else
        run_op(8'hA6, 4'd0, mk(255, 6, 1'b1), 8, 1'b0);
`endif
        run_op(8'd100, 4'd3, mk(33, 1, 1'b0), 8, 1'b1);

        // Reset in the middle of a run: no result, all outputs cleared.
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_div_zero", int'(div_zero), 0);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("abort_no_done", int'(done), 0);
        run_op(8'd9, 4'd2, mk(4, 1, 1'b0), 8, 1'b0);

        // start held high across three back-to-back operations.
        sb.push_back(mk(28, 4, 1'b0));
        sb.push_back(mk(9, 9, 1'b0));
        sb.push_back(mk(1, 0, 1'b0));
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge sys_clk);
        #1;
        lat_a = 0;
        do begin
            @(posedge sys_clk);
            #1;
            lat_a++;
        end while (!done && lat_a < 30);
        chk("b2b_first_latency", lat_a, 8);
        dividend = 8'd99;
        divisor  = 4'd10;
        lat_b = 0;
        do begin
            @(posedge sys_clk);
            #1;
            lat_b++;
        end while (!done && lat_b < 30);
        chk("b2b_spacing_1", lat_b, 9);
        dividend = 8'd15;
        divisor  = 4'd15;
        lat_b = 0;
        do begin
            @(posedge sys_clk);
            #1;
            lat_b++;
        end while (!done && lat_b < 30);
        chk("b2b_spacing_2", lat_b, 9);
        start = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("b2b_done_held", int'(done), 1);

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
`ifdef MICRO_DIV_ZERO_TRAP_EN
                run_op(8'(a), 4'(b), ref_model(8'(a), 4'(b)), (b == 0) ? 0 : 8, 1'b0);
`else
                run_op(8'(a), 4'(b), ref_model(8'(a), 4'(b)), 8, 1'b0);
`endif
            end
        end

        @(posedge sys_clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
